result_element_store: RTL and testbench

- Responder end of the multiplier's z_* result handshake.
- Holds the m x m block of 32-bit result words that the sequential matrix multiplier writes back.
- Serves the partial sum at the current z_i/z_j as current_element, for read-modify-write accumulation across k tiles.
- Streams the finished block out row-major on request. Sits beside row_col_multiplier, one instance per result block.

---
 rtl/matrix_pkg.sv | 12 +
 rtl/result_element_store_if.sv | 29 ++
 rtl/result_mem.sv | 35 +++
 rtl/result_element_store.sv | 81 ++++++++
 tb/tb_result_element_store.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared word width, result-store FSM encodings and index-width helper.
package matrix_pkg;
  localparam int W = 32;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK = 2'd1, S_DUMP = 2'd2} state_t;
  // Never returns 0, so an m=1 block still gets a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/result_element_store_if.sv
// result_element_store_if: z_* write handshake, clear, and the dump stream of one result block.
interface result_element_store_if import matrix_pkg::*; #(
  parameter int m = 4,
  parameter int w = W,
  parameter int m_len = clog2(m)
) ();
  logic z_stb;
  logic [w-1:0] z_out;
  logic [m_len-1:0] z_i;
  logic [m_len-1:0] z_j;
  logic z_ack;
  logic [w-1:0] current_element;
  logic clear;
  logic dump_start;
  logic dump_valid;
  logic dump_ready;
  logic [w-1:0] dump_data;
  logic [m_len-1:0] dump_i;
  logic [m_len-1:0] dump_j;
  logic busy;
  modport master (
    output z_stb, z_out, z_i, z_j, clear, dump_start, dump_ready,
    input z_ack, current_element, dump_valid, dump_data, dump_i, dump_j, busy
  );
  modport slave (
    input z_stb, z_out, z_i, z_j, clear, dump_start, dump_ready,
    output z_ack, current_element, dump_valid, dump_data, dump_i, dump_j, busy
  );
endinterface

// File: rtl/result_mem.sv
// result_mem: m x m word array with per-entry valid bits, one write port, two combinational reads.
module result_mem import matrix_pkg::*; #(
  parameter int m = 4,
  parameter int w = W,
  parameter int m_len = clog2(m)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic we,
  input  logic [m_len-1:0] wi,
  input  logic [m_len-1:0] wj,
  input  logic [w-1:0] wd,
  input  logic [m_len-1:0] ri,
  input  logic [m_len-1:0] rj,
  output logic [w-1:0] rd,
  input  logic [m_len-1:0] di,
  input  logic [m_len-1:0] dj,
  output logic [w-1:0] dd
);
  localparam int n = m * m;
  localparam int aw = clog2(n);
  logic [w-1:0] mem [n];
  logic [n-1:0] vld;
  function automatic logic [aw-1:0] idx(input logic [m_len-1:0] i, input logic [m_len-1:0] j);
    return aw'(i) * aw'(m) + aw'(j);
  endfunction
  always_ff @(posedge clk)
    if (we) mem[idx(wi, wj)] <= wd;
  // Clear is applied before the write, so a same-cycle write survives it.
  always_ff @(posedge clk)
    vld <= rst ? '0 : ((clear ? '0 : vld) | (we ? n'(1) << idx(wi, wj) : '0));
  assign rd = vld[idx(ri, rj)] ? mem[idx(ri, rj)] : '0;
  assign dd = vld[idx(di, dj)] ? mem[idx(di, dj)] : '0;
endmodule

// File: rtl/result_element_store.sv
// result_element_store: responder for the multiplier's z_* writes; serves partial sums and streams the block out.
module result_element_store import matrix_pkg::*; #(
  parameter int m = 4,
  parameter int w = W,
  parameter int m_len = clog2(m)
) (
  input logic clk,
  input logic rst,
  result_element_store_if.slave bus
);
  localparam logic [m_len-1:0] top = m_len'(m - 1);
  state_t state;
  logic z_ack;
  logic dump_valid;
  logic [m_len-1:0] dump_i;
  logic [m_len-1:0] dump_j;
  logic idle;
  logic last;
  assign idle = state == S_IDLE;
  assign last = dump_i == top && dump_j == top;
  result_mem #(.m(m), .w(w), .m_len(m_len)) u_mem (
    .clk(clk),
    .rst(rst),
    .clear(idle && bus.clear),
    .we(!rst && idle && bus.z_stb),
    .wi(bus.z_i),
    .wj(bus.z_j),
    .wd(bus.z_out),
    .ri(bus.z_i),
    .rj(bus.z_j),
    .rd(bus.current_element),
    .di(dump_i),
    .dj(dump_j),
    .dd(bus.dump_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      z_ack <= 1'b0;
      dump_valid <= 1'b0;
      dump_i <= '0;
      dump_j <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (bus.z_stb) begin
            state <= S_ACK;
            z_ack <= 1'b1;
          end else if (bus.dump_start) begin
            state <= S_DUMP;
            dump_valid <= 1'b1;
            dump_i <= '0;
            dump_j <= '0;
          end
        S_ACK:
          if (!bus.z_stb) begin
            state <= S_IDLE;
            z_ack <= 1'b0;
          end
        S_DUMP:
          if (bus.dump_ready) begin
            if (last) begin
              state <= S_IDLE;
              dump_valid <= 1'b0;
              dump_i <= '0;
              dump_j <= '0;
            end else begin
              dump_j <= dump_j == top ? '0 : dump_j + 1'b1;
              if (dump_j == top) dump_i <= dump_i + 1'b1;
            end
          end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign bus.z_ack = z_ack;
  assign bus.dump_valid = dump_valid;
  assign bus.dump_i = dump_i;
  assign bus.dump_j = dump_j;
  assign bus.busy = !idle;
endmodule

// File: tb/tb_result_element_store.sv
// tb_result_element_store: randomized writes/clears/dumps checked against an array model of the block.
module tb_result_element_store;
  import matrix_pkg::*;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  result_element_store_if #(.m(4), .w(32)) bus();
  result_element_store #(.m(4), .w(32)) dut(.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  int cnt = 0;
  bit en = 0;
  logic [31:0] mm [16];
  bit mv [16];
  function automatic logic [31:0] exp_at(int i, int j);
    return mv[i * 4 + j] ? mm[i * 4 + j] : 32'h0;
  endfunction
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic inval;
    for (int k = 0; k < 16; k++) mv[k] = 0;
  endtask
  // Checks every cycle; cnt is the number of dump words accepted so far.
  always begin
    @(posedge clk);
    #2;
    if (en) begin
      chk("cur", bus.current_element, exp_at(int'(bus.z_i), int'(bus.z_j)));
      if (bus.dump_valid) begin
        chk("dump_i", 32'(bus.dump_i), 32'((cnt % 16) / 4));
        chk("dump_j", 32'(bus.dump_j), 32'(cnt % 4));
        chk("dump_data", bus.dump_data, exp_at((cnt % 16) / 4, cnt % 4));
        if (bus.dump_ready && !rst) cnt++;
      end
    end
  end
  task automatic wr(int i, int j, logic [31:0] d, int hold, bit clr);
    bus.z_i = 2'(i);
    bus.z_j = 2'(j);
    bus.z_out = d;
    bus.z_stb = 1;
    bus.clear = clr;
    step;
    bus.clear = 0;
    if (clr) inval;
    mm[i * 4 + j] = d;
    mv[i * 4 + j] = 1;
    bus.z_out = ~d;
    for (int c = 0; c < hold; c++) begin
      chk("ack_hi", 32'(bus.z_ack), 32'd1);
      if (c < hold - 1) step;
    end
    bus.z_stb = 0;
    step;
    chk("ack_lo", 32'(bus.z_ack), 32'd0);
    chk("busy_after_wr", 32'(bus.busy), 32'd0);
  endtask
  task automatic clr_only;
    bus.clear = 1;
    step;
    bus.clear = 0;
    inval;
  endtask
  task automatic dump(int mode, bit clr);
    cnt = 0;
    bus.dump_start = 1;
    bus.clear = clr;
    step;
    bus.dump_start = 0;
    bus.clear = 0;
    if (clr) inval;
    chk("dv_start", 32'(bus.dump_valid), 32'd1);
    chk("busy_dump", 32'(bus.busy), 32'd1);
    for (int c = 0; c < 300 && cnt < 16; c++) begin
      bus.dump_ready = mode == 0 ? (c % 2 == 0) : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      step;
    end
    bus.dump_ready = 0;
    chk("dump_cnt", 32'(cnt), 32'd16);
    chk("dv_end", 32'(bus.dump_valid), 32'd0);
    chk("busy_end", 32'(bus.busy), 32'd0);
  endtask
  task automatic sweep;
    for (int k = 0; k < 16; k++) begin
      bus.z_i = 2'(k / 4);
      bus.z_j = 2'(k % 4);
      step;
    end
  endtask
  initial begin
    bus.z_stb = 0;
    bus.z_out = 0;
    bus.z_i = 0;
    bus.z_j = 0;
    bus.clear = 0;
    bus.dump_start = 0;
    bus.dump_ready = 0;
    inval;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_ack", 32'(bus.z_ack), 32'd0);
    chk("rst_dv", 32'(bus.dump_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_di", 32'(bus.dump_i), 32'd0);
    chk("rst_dj", 32'(bus.dump_j), 32'd0);
    chk("rst_cur", bus.current_element, 32'h0);
    en = 1;
    wr(1, 2, 32'h3F800000, 1, 0);
    bus.z_i = 1;
    bus.z_j = 2;
    step;
    chk("lit_12", bus.current_element, 32'h3F800000);
    bus.z_i = 0;
    bus.z_j = 0;
    step;
    chk("lit_00", bus.current_element, 32'h0);
    wr(1, 2, 32'h40000000, 5, 0);
    bus.z_i = 1;
    bus.z_j = 2;
    step;
    chk("lit_12b", bus.current_element, 32'h40000000);
    for (int k = 0; k < 16; k++) wr(k / 4, k % 4, 32'h100 + 32'(k), 1, 0);
    bus.z_i = 3;
    bus.z_j = 3;
    step;
    chk("lit_33", bus.current_element, 32'h10F);
    dump(0, 0);
    wr(3, 3, 32'hAA, 1, 1);
    chk("lit_aa", bus.current_element, 32'hAA);
    sweep;
    bus.z_i = 2;
    bus.z_j = 1;
    step;
    chk("lit_clr", bus.current_element, 32'h0);
    for (int k = 0; k < 16; k++) wr(k / 4, k % 4, $urandom, 1, 0);
    cnt = 0;
    bus.dump_start = 1;
    step;
    bus.dump_start = 0;
    bus.z_i = 3;
    bus.z_j = 0;
    bus.z_out = 32'hBEEF;
    bus.z_stb = 1;
    for (int c = 0; c < 300 && cnt < 16; c++) begin
      bus.dump_ready = c >= 3;
      chk("no_ack_dump", 32'(bus.z_ack), 32'd0);
      step;
    end
    bus.dump_ready = 0;
    chk("dump_cnt2", 32'(cnt), 32'd16);
    chk("ack_wait", 32'(bus.z_ack), 32'd0);
    step;
    mm[12] = 32'hBEEF;
    mv[12] = 1;
    chk("ack_after_dump", 32'(bus.z_ack), 32'd1);
    bus.z_stb = 0;
    step;
    chk("ack_drop", 32'(bus.z_ack), 32'd0);
    chk("lit_beef", bus.current_element, 32'hBEEF);
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) wr($urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(1, 4), r == 0);
      else if (r == 6) clr_only;
      else dump(r == 9 ? 2 : 1, r == 9 && $urandom_range(0, 1) == 1);
      bus.z_i = 2'($urandom_range(0, 3));
      bus.z_j = 2'($urandom_range(0, 3));
      step;
    end
    cnt = 0;
    bus.dump_start = 1;
    step;
    bus.dump_start = 0;
    bus.dump_ready = 1;
    for (int c = 0; c < 50 && cnt < 3; c++) step;
    rst = 1;
    step;
    rst = 0;
    inval;
    bus.dump_ready = 0;
    chk("rst_mid_dv", 32'(bus.dump_valid), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 16; k++) begin
      bus.z_i = 2'(k / 4);
      bus.z_j = 2'(k % 4);
      step;
      chk("post_rst", bus.current_element, 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
